// File: rtl/keycode_event_queue.sv
// Turns successive HID boot-keyboard reports into an ordered FIFO of key press/release events.
// Releases are scanned first, then presses, one slot per cycle; duplicates and ErrorRollOver are filtered.
module keycode_event_queue #(
    parameter int KEYS  = 6,
    parameter int KW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        report_valid,
    input  logic [KEYS*KW-1:0]          report,
    output logic                        report_ready,
    output logic                        ev_valid,
    output logic [KW-1:0]               ev_code,
    output logic                        ev_press,
    input  logic                        ev_pop,
    output logic                        overflow,
    input  logic                        clr_overflow,
    output logic [$clog2(KEYS+1)-1:0]   held_count
);

    localparam int IW = (KEYS > 1) ? $clog2(KEYS) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(KEYS + 1);
    localparam logic [IW-1:0] LAST     = IW'(KEYS - 1);
    localparam logic [KW-1:0] ROLLOVER = KW'(1);

    typedef enum logic [1:0] {IDLE, SCAN_REL, SCAN_PRS, COMMIT} state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   old_q [KEYS];
    logic [KW-1:0]   new_q [KEYS];
    logic [IW-1:0]   idx;
    logic            rollover;
    logic [CW-1:0]   distinct_cnt;

    logic [KW-1:0]   cand;
    logic            hit, dup, push, push_press;

    logic [KW:0]     mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            empty, full, do_push, do_pop, drop;

    always_comb begin
        rollover = 1'b0;
        for (int i = 0; i < KEYS; i++)
            if (report[i*KW +: KW] == ROLLOVER) rollover = 1'b1;
    end

    always_comb begin
        distinct_cnt = '0;
        for (int i = 0; i < KEYS; i++) begin
            logic uniq;
            uniq = (new_q[i] != '0);
            for (int j = 0; j < i; j++)
                if (new_q[j] == new_q[i]) uniq = 1'b0;
            if (uniq) distinct_cnt = distinct_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (latch).
        state_nxt = state;
        case (state)
            IDLE:     if (report_valid && !rollover) state_nxt = SCAN_REL;
            SCAN_REL: if (idx == LAST) state_nxt = SCAN_PRS;
            SCAN_PRS: if (idx == LAST) state_nxt = COMMIT;
            COMMIT:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // The slot under scan is pushed when nonzero, absent from the other report, and first of its value.
    always_comb begin
        report_ready = (state == IDLE);
        cand       = '0;
        hit        = 1'b0;
        dup        = 1'b0;
        push       = 1'b0;
        push_press = 1'b0;
        if (state == SCAN_REL) begin
            cand = old_q[idx];
            for (int j = 0; j < KEYS; j++) begin
                if (new_q[j] == cand) hit = 1'b1;
                if (j < int'(idx) && old_q[j] == cand) dup = 1'b1;
            end
            push = (cand != '0) && !hit && !dup;
        end else if (state == SCAN_PRS) begin
            cand = new_q[idx];
            for (int j = 0; j < KEYS; j++) begin
                if (old_q[j] == cand) hit = 1'b1;
                if (j < int'(idx) && new_q[j] == cand) dup = 1'b1;
            end
            push       = (cand != '0) && !hit && !dup;
            push_press = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            held_count <= '0;
            for (int i = 0; i < KEYS; i++) begin
                old_q[i] <= '0;
                new_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (report_valid) begin
                    for (int i = 0; i < KEYS; i++) new_q[i] <= report[i*KW +: KW];
                    idx <= '0;
                end
                SCAN_REL, SCAN_PRS: idx <= (idx == LAST) ? '0 : idx + IW'(1);
                COMMIT: begin
                    for (int i = 0; i < KEYS; i++) old_q[i] <= new_q[i];
                    held_count <= distinct_cnt;
                end
                default: ;
            endcase
        end
    end

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = ev_pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            overflow <= drop | (overflow & ~clr_overflow);
        end
    end

    // NOTE: the storage array has no reset; entries are only observable between push and pop, and the head is gated below.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= {cand, push_press};
    end

    assign ev_valid = !empty;
    assign {ev_code, ev_press} = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: doc/keycode_event_queue.md
# keycode_event_queue

Converts raw USB HID boot-keyboard reports into an ordered queue of discrete key press/release events. This lets game logic consume input edges instead of polling a single keycode register. It sits between the NIOS-driven keycode export path and the game FSM. It supports KEYS simultaneous keycodes per report and a DEPTH-entry event FIFO.

## Interface
- KEYS, 6, keycode slots per report (1..8)
- KW, 8, keycode width in bits
- DEPTH, 16, event FIFO entries; must be a power of two, ≥2
- Clk  in  1  system clock; all logic rising-edge
- Reset  in  1  asynchronous, active-high; clears all state
- report_valid  in  1  new report offered this cycle
- report  in  KEYS*KW  slot i at bits [i*KW +: KW]; code 0 = empty slot
- report_ready  out  1  block accepts a report this cycle
- ev_valid  out  1  FIFO non-empty
- ev_code  out  KW  keycode at FIFO head
- ev_press  out  1  head event type: 1 = press, 0 = release
- ev_pop  in  1  consume head event; ignored when ev_valid=0
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- clr_overflow  in  1  clears overflow
- held_count  out  clog2(KEYS+1)  distinct keys held per last committed report

## Operation
- State: old[] (last committed report, KEYS slots), new[] (latched incoming report), index i, FIFO.
- FSM states: IDLE, SCAN_REL, SCAN_PRS, COMMIT.
- IDLE: report_ready=1. On report_valid, latch new[]=report, i=0.
  - If any slot equals 0x01 (HID ErrorRollOver), discard the report: stay in IDLE, no events, old[] unchanged.
  - Otherwise go to SCAN_REL.
- SCAN_REL: one slot per cycle, i = 0..KEYS-1. Push {old[i], release} when all three hold:
  - old[i] ≠ 0;
  - old[i] matches no new[] slot;
  - old[i] ≠ old[j] for all j<i (duplicate suppression).
  - After i=KEYS-1, set i=0 and go to SCAN_PRS.
- SCAN_PRS: one slot per cycle. Push {new[i], press} when:
  - new[i] ≠ 0;
  - new[i] matches no old[] slot;
  - new[i] is not a duplicate of new[j], j<i.
  - After i=KEYS-1, go to COMMIT.
- COMMIT: old[] ← new[]; held_count ← count of distinct nonzero new[] codes. Go to IDLE.
- Event order: all releases of a report precede its presses; within each group, ascending slot index.
- report_valid while report_ready=0: the report is ignored, with no flag and no stall.
- FIFO:
  - Push when full with no pop in the same cycle: the event is dropped and overflow ← 1.
  - Push and pop in the same cycle when full: both take effect; no overflow.
  - Push and pop in the same cycle when empty: the push lands; ev_valid rises the next cycle.
- overflow: clr_overflow clears it. If clr_overflow and a new drop occur in the same cycle, overflow remains 1.
- Pointers are log2(DEPTH)+1 bits; full/empty are determined by the MSB compare.

## Timing
- Reset values: report_ready=1, ev_valid=0, ev_code=0, ev_press=0, overflow=0, held_count=0, old[] all 0, FSM=IDLE.
- Report accepted at cycle 0 (IDLE with report_valid). Timeline:
  - SCAN_REL: cycles 1..KEYS.
  - SCAN_PRS: cycles KEYS+1..2KEYS.
  - COMMIT: cycle 2KEYS+1.
  - report_ready=1 again at cycle 2KEYS+2 (14 cycles for KEYS=6).
- A rollover-discarded report keeps report_ready=1 continuously.
- An event pushed in cycle n is visible on ev_valid/ev_code/ev_press in cycle n+1 (registered FIFO head).
- ev_pop in cycle n advances the head in cycle n+1.
- held_count updates in the cycle after COMMIT.
- Reset asserted mid-scan aborts the scan and clears the FIFO and old[]. The next report therefore generates presses for every held key.

## Test plan
- Reset, then report {0x04,0,0,0,0,0} → exactly one event {0x04, press}, ev_valid at cycle 8; held_count=1; report_ready back at cycle 14.
- Report {0x04,0x05,…} then {0x05,0x06,…} → second report yields {0x04, release} then {0x06, press}; held_count=2.
- Report {0x07,0x07,0,…} → single {0x07, press}, held_count=1. A following all-zero report → single {0x07, release}.
- With {0x04} held, report {0x01,0x01,…} → no events; a third report {0x04} → no events, held_count=1.
- DEPTH=4, no pops, reports producing 6 presses → exactly 4 events queued, overflow=1. Pop all four in order, assert clr_overflow → overflow=0, ev_valid=0.
- Assert Reset during SCAN_PRS → all outputs at reset values next cycle; re-sending the previous report yields presses for all its keys.
